// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: load opcodes and write-back source encodings.
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

endpackage

// File: rtl/regfile_32x32.sv
// Architectural register file: one synchronous write port, two combinational
// read ports with same-cycle write bypass. Register 0 is hardwired to zero.
module regfile_32x32 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREG  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(NREG)-1:0]  raddr_a,
    input  logic [$clog2(NREG)-1:0]  raddr_b,
    output logic [WIDTH-1:0]         rdata_a,
    output logic [WIDTH-1:0]         rdata_b
);

    localparam int unsigned AW = $clog2(NREG);

    logic [WIDTH-1:0] mem_q [NREG];

    // Storage update: async clear, write on posedge, register 0 never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read ports: bypass the in-flight write, otherwise return array content.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (we && (raddr_a == waddr) && (waddr != AW'(0))) begin
            rdata_a = wdata;
        end else if (raddr_a != '0) begin
            rdata_a = mem_q[raddr_a];
        end
        if (we && (raddr_b == waddr) && (waddr != AW'(0))) begin
            rdata_b = wdata;
        end else if (raddr_b != '0) begin
            rdata_b = mem_q[raddr_b];
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: load extraction, write-back mux, retired-instruction
// counter, and the architectural register file.
module wb_regfile
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREG  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [29:0]      fourPC,
    input  logic [1:0]       memToReg,
    input  logic [31:0]      readData,
    input  logic [31:0]      aluResult,
    input  logic [4:0]       writeDataReg,
    input  logic             regWrite,
    input  logic [31:0]      instruction,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    output logic [31:0]      rs_data,
    output logic [31:0]      rt_data,
    output logic [31:0]      wb_data,
    output logic             wb_we,
    output logic [31:0]      instret
);

    logic [5:0]  opcode;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] instret_q;

    assign opcode = instruction[31:26];

    // Little-endian lane select: byte k from offset, halfword from offset bit 1.
    always_comb begin
        ld_byte = readData[7:0];
        unique case (aluResult[1:0])
            2'd0: ld_byte = readData[7:0];
            2'd1: ld_byte = readData[15:8];
            2'd2: ld_byte = readData[23:16];
            2'd3: ld_byte = readData[31:24];
            default: ld_byte = readData[7:0];
        endcase
        ld_half = aluResult[1] ? readData[31:16] : readData[15:0];
    end

    // Extend the selected lane according to the load opcode.
    always_comb begin
        load_data = readData;
        case (opcode)
            OP_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  load_data = {24'h0, ld_byte};
            OP_LH:   load_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  load_data = {16'h0, ld_half};
            default: load_data = readData;
        endcase
    end

    // Write-back source select; the reserved encoding falls back to the ALU.
    always_comb begin
        wb_data = aluResult;
        case (memToReg)
            WB_ALU:  wb_data = aluResult;
            WB_MEM:  wb_data = load_data;
            WB_LINK: wb_data = {fourPC, 2'b00};
            default: wb_data = aluResult;
        endcase
    end

    assign wb_we = regWrite && (writeDataReg != 5'd0);

    // Retired-instruction counter; zero words are bubbles and do not count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_q <= '0;
        end else if (instruction != 32'h0) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;

    regfile_32x32 #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_we),
        .waddr   (writeDataReg),
        .wdata   (wb_data),
        .raddr_a (rs_addr),
        .raddr_b (rt_addr),
        .rdata_a (rs_data),
        .rdata_b (rt_data)
    );

endmodule
